// File: rtl/connect_mc_ooo_if.sv
// connect_mc_ooo_if: bundle of every handshake and bus signal of the N-to-1
// memory-controller interconnect.
//
// Modports:
//   master - interconnect view. It drives the request channel toward the memory
//            controller and the ready/response lanes toward the clients.
//   slave  - environment view (clients plus memory controller), with the
//            directions reversed.
//
// Signals:
//   SLAVE_RECEIVE_*  per-client request lanes (valid, address, data) and the
//                    one-hot ready back to the clients.
//   SLAVE_SEND_*     per-client response lanes: one-hot valid, broadcast data,
//                    and the per-client ready.
//   MASTER_SEND_*    single request channel toward the memory controller.
//   MASTER_RECEIVE_* single response channel from the memory controller.
interface connect_mc_ooo_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONNECT_NUM = 3
);
  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID;
  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR;
  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA;
  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY;
  logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA;
  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY;
  logic                              MASTER_SEND_ADDR_VALID;
  logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR;
  logic                              MASTER_SEND_DATA_VALID;
  logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA;
  logic                              MASTER_SEND_READY;
  logic                              MASTER_RECEIVE_VALID;
  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA;
  logic                              MASTER_RECEIVE_READY;

  modport master (
    input  SLAVE_RECEIVE_ADDR_VALID, SLAVE_RECEIVE_ADDR, SLAVE_RECEIVE_DATA_VALID,
    input  SLAVE_RECEIVE_DATA, SLAVE_SEND_READY, MASTER_SEND_READY,
    input  MASTER_RECEIVE_VALID, MASTER_RECEIVE_DATA,
    output SLAVE_RECEIVE_READY, SLAVE_SEND_VALID, SLAVE_SEND_DATA,
    output MASTER_SEND_ADDR_VALID, MASTER_SEND_ADDR, MASTER_SEND_DATA_VALID,
    output MASTER_SEND_DATA, MASTER_RECEIVE_READY
  );

  modport slave (
    output SLAVE_RECEIVE_ADDR_VALID, SLAVE_RECEIVE_ADDR, SLAVE_RECEIVE_DATA_VALID,
    output SLAVE_RECEIVE_DATA, SLAVE_SEND_READY, MASTER_SEND_READY,
    output MASTER_RECEIVE_VALID, MASTER_RECEIVE_DATA,
    input  SLAVE_RECEIVE_READY, SLAVE_SEND_VALID, SLAVE_SEND_DATA,
    input  MASTER_SEND_ADDR_VALID, MASTER_SEND_ADDR, MASTER_SEND_DATA_VALID,
    input  MASTER_SEND_DATA, MASTER_RECEIVE_READY
  );
endinterface

// File: rtl/connect_mc_ooo.sv
// connect_mc_ooo: N-to-1 memory-controller interconnect.
//
// CONNECT_NUM clients share one memory-controller port. Up to OUTSTANDING
// requests may be accepted before any of them is answered. A tag FIFO records
// which client owns each accepted request, so that every response goes back,
// in order, to the client that issued it.
//
// Ports:
//   CLK - clock; all state updates on the rising edge.
//   RST - synchronous, active-high reset.
//   bus - connect_mc_ooo_if.master; carries all request and response signals.
//
// Build option:
//   CONNECT_MC_RR_EN - when defined, arbitration is round-robin. When it is not
//                      defined (the default), arbitration is fixed priority and
//                      the highest-numbered valid client wins.
//
// Grant lock: once a request has been offered to the controller and not yet
// accepted, the grant stays on that client until the controller accepts it.
module connect_mc_ooo #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONNECT_NUM = 3,
  parameter int unsigned OUTSTANDING = 4
) (
  input logic              CLK,
  input logic              RST,
  connect_mc_ooo_if.master bus
);
  localparam int unsigned TW = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam logic [PW-1:0] LastPtr = PW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] Full    = CW'(OUTSTANDING);

  logic [TW-1:0] tag_mem_q [OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          lock_q;
  logic [TW-1:0] locked_idx_q;
`ifdef CONNECT_MC_RR_EN
  localparam logic [TW-1:0] LastTag = TW'(CONNECT_NUM - 1);
  logic [TW-1:0] rr_ptr_q;
`endif

  logic [TW-1:0]         grant, head;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_dvalid, req_valid, accept;
  logic                  not_empty, head_ready, rsp_ready, pop;

  always_comb begin : arbitrate
    int idx;
    idx   = 0;
    grant = '0;
`ifdef CONNECT_MC_RR_EN
    // Walk the search order backwards so the client nearest the pointer is
    // written last and therefore wins.
    for (int k = int'(CONNECT_NUM) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(CONNECT_NUM)) idx = idx - int'(CONNECT_NUM);
      for (int j = 0; j < int'(CONNECT_NUM); j++) begin
        if (j == idx && bus.SLAVE_RECEIVE_ADDR_VALID[j]) grant = TW'(j);
      end
    end
`else
    for (int k = 0; k < int'(CONNECT_NUM); k++) begin
      if (bus.SLAVE_RECEIVE_ADDR_VALID[k]) grant = TW'(k);
    end
`endif
    if (lock_q) grant = locked_idx_q;
  end

  always_comb begin : request_path
    sel_addr   = '0;
    sel_data   = '0;
    sel_dvalid = 1'b0;
    for (int k = 0; k < int'(CONNECT_NUM); k++) begin
      if (grant == TW'(k)) begin
        sel_addr   = bus.SLAVE_RECEIVE_ADDR[ADDR_WIDTH*k +: ADDR_WIDTH];
        sel_data   = bus.SLAVE_RECEIVE_DATA[DATA_WIDTH*k +: DATA_WIDTH];
        sel_dvalid = bus.SLAVE_RECEIVE_DATA_VALID[k];
      end
    end
    // Gating on the registered count means a request is never offered while
    // the FIFO is full, even if a pop happens in the same cycle.
    req_valid = (|bus.SLAVE_RECEIVE_ADDR_VALID) && (count_q < Full) && !RST;
    accept    = req_valid && bus.MASTER_SEND_READY;
    bus.MASTER_SEND_ADDR_VALID = req_valid;
    bus.MASTER_SEND_ADDR       = sel_addr;
    bus.MASTER_SEND_DATA_VALID = sel_dvalid && req_valid;
    bus.MASTER_SEND_DATA       = sel_data;
    bus.SLAVE_RECEIVE_READY    = '0;
    for (int k = 0; k < int'(CONNECT_NUM); k++) begin
      if (grant == TW'(k)) bus.SLAVE_RECEIVE_READY[k] = accept;
    end
  end

  always_comb begin : response_path
    head       = tag_mem_q[rd_ptr_q];
    not_empty  = (count_q != '0) && !RST;
    head_ready = 1'b0;
    bus.SLAVE_SEND_VALID = '0;
    for (int k = 0; k < int'(CONNECT_NUM); k++) begin
      if (head == TW'(k)) begin
        head_ready              = bus.SLAVE_SEND_READY[k];
        bus.SLAVE_SEND_VALID[k] = bus.MASTER_RECEIVE_VALID && not_empty;
      end
    end
    rsp_ready = not_empty && head_ready;
    pop       = bus.MASTER_RECEIVE_VALID && rsp_ready;
    bus.MASTER_RECEIVE_READY = rsp_ready;
    bus.SLAVE_SEND_DATA      = {CONNECT_NUM{bus.MASTER_RECEIVE_DATA}};
  end

  // Tag storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (accept) tag_mem_q[wr_ptr_q] <= grant;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
`ifdef CONNECT_MC_RR_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      if (accept) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
      if (accept) begin
        lock_q <= 1'b0;
      end else if (req_valid) begin
        lock_q       <= 1'b1;
        locked_idx_q <= grant;
      end
`ifdef CONNECT_MC_RR_EN
      if (accept) rr_ptr_q <= (grant == LastTag) ? '0 : grant + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_connect_mc_ooo.sv
// Directed bench for connect_mc_ooo with a queue-based scoreboard.
//
// The stimulus process pushes the expected grant or response into a queue.
// Independent monitor processes pop from those queues and compare on every
// request handshake and every response handshake.
module tb_connect_mc_ooo;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned N   = 3;
  localparam int unsigned OST = 4;

  typedef struct {
    int          lane;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  connect_mc_ooo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N)) bus ();

  connect_mc_ooo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CONNECT_NUM(N),
    .OUTSTANDING(OST)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  exp_t        req_q[$];
  exp_t        rsp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] slave_addr [N];
  logic [31:0] slave_data [N];
  int          arb_exp [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.SLAVE_RECEIVE_ADDR_VALID = '0;
    bus.MASTER_SEND_READY        = 1'b0;
    bus.MASTER_RECEIVE_VALID     = 1'b0;
    bus.SLAVE_SEND_READY         = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic exp_req(input int lane);
    req_q.push_back('{lane: lane, val: slave_addr[lane]});
  endtask

  task automatic exp_rsp(input int lane, input logic [31:0] v);
    rsp_q.push_back('{lane: lane, val: v});
  endtask

  always @(negedge clk) begin : req_monitor
    exp_t e;
    if (bus.MASTER_SEND_ADDR_VALID === 1'b1 && bus.MASTER_SEND_READY === 1'b1) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL req_unexpected: got grant %0b, expected no accept",
                 bus.SLAVE_RECEIVE_READY);
      end else begin
        e = req_q.pop_front();
        chk("req_grant", 128'(bus.SLAVE_RECEIVE_READY), 128'(1 << e.lane));
        chk("req_addr", 128'(bus.MASTER_SEND_ADDR), 128'(e.val));
        chk("req_data", 128'(bus.MASTER_SEND_DATA), 128'(slave_data[e.lane]));
      end
    end
  end

  always @(negedge clk) begin : rsp_monitor
    exp_t e;
    if (bus.MASTER_RECEIVE_VALID === 1'b1 && bus.MASTER_RECEIVE_READY === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got lanes %0b, expected no accept",
                 bus.SLAVE_SEND_VALID);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_lane", 128'(bus.SLAVE_SEND_VALID), 128'(1 << e.lane));
        chk("rsp_data", 128'(bus.SLAVE_SEND_DATA[e.lane*DW +: DW]), 128'(e.val));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    slave_addr[0] = 32'h0000_00A0;
    slave_addr[1] = 32'h0000_0100;
    slave_addr[2] = 32'h0000_02C0;
    slave_data[0] = 32'h1111_0000;
    slave_data[1] = 32'h2222_0001;
    slave_data[2] = 32'h3333_0002;
`ifdef CONNECT_MC_RR_EN
    arb_exp = '{0, 1, 2, 0, 1};
`else
    arb_exp = '{2, 2, 2, 2, 2};
`endif
    bus.SLAVE_RECEIVE_ADDR       = {slave_addr[2], slave_addr[1], slave_addr[0]};
    bus.SLAVE_RECEIVE_DATA       = {slave_data[2], slave_data[1], slave_data[0]};
    bus.SLAVE_RECEIVE_DATA_VALID = '1;
    bus.MASTER_RECEIVE_DATA      = '0;

    // Outputs stay quiet during reset even with every input asserted.
    rst = 1'b1;
    bus.SLAVE_RECEIVE_ADDR_VALID = '1;
    bus.MASTER_SEND_READY        = 1'b1;
    bus.MASTER_RECEIVE_VALID     = 1'b1;
    bus.SLAVE_SEND_READY         = '1;
    step();
    step();
    @(negedge clk);
    chk("rst_addr_valid", 128'(bus.MASTER_SEND_ADDR_VALID), 128'd0);
    chk("rst_data_valid", 128'(bus.MASTER_SEND_DATA_VALID), 128'd0);
    chk("rst_recv_ready", 128'(bus.SLAVE_RECEIVE_READY), 128'd0);
    chk("rst_mrecv_ready", 128'(bus.MASTER_RECEIVE_READY), 128'd0);
    chk("rst_send_valid", 128'(bus.SLAVE_SEND_VALID), 128'd0);

    // A single request from slave 1, answered with 0xDEAD.
    do_reset();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b010;
    bus.MASTER_SEND_READY        = 1'b1;
    exp_req(1);
    @(negedge clk);
    chk("single_dvalid", 128'(bus.MASTER_SEND_DATA_VALID), 128'd1);
    step();
    bus.SLAVE_RECEIVE_ADDR_VALID = '0;
    bus.MASTER_RECEIVE_VALID     = 1'b1;
    bus.MASTER_RECEIVE_DATA      = 32'h0000_DEAD;
    bus.SLAVE_SEND_READY         = '1;
    exp_rsp(1, 32'h0000_DEAD);
    @(negedge clk);
    chk("single_send_valid", 128'(bus.SLAVE_SEND_VALID), 128'b010);
    step();
    @(negedge clk);
    chk("single_empty_ready", 128'(bus.MASTER_RECEIVE_READY), 128'd0);
    chk("single_empty_valid", 128'(bus.SLAVE_SEND_VALID), 128'd0);

    // Continuous contention. The FIFO fills after four accepts, and one
    // response then lets the fifth request through.
    do_reset();
    for (int i = 0; i < 4; i++) exp_req(arb_exp[i]);
    bus.SLAVE_RECEIVE_ADDR_VALID = '1;
    bus.MASTER_SEND_READY        = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("full_stall", 128'(bus.MASTER_SEND_ADDR_VALID), 128'd0);
    step();
    bus.MASTER_RECEIVE_VALID = 1'b1;
    bus.MASTER_RECEIVE_DATA  = 32'hA5A5_0001;
    bus.SLAVE_SEND_READY     = '1;
    exp_rsp(arb_exp[0], 32'hA5A5_0001);
    @(negedge clk);
    chk("full_stall_pop_cycle", 128'(bus.MASTER_SEND_ADDR_VALID), 128'd0);
    step();
    bus.MASTER_RECEIVE_VALID = 1'b0;
    exp_req(arb_exp[4]);
    @(negedge clk);
    chk("fifth_accept", 128'(bus.MASTER_SEND_ADDR_VALID), 128'd1);
    step();

    // The grant stays locked on slave 0 while the controller is stalled.
    do_reset();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b001;
    @(negedge clk);
    chk("lock_c0_addr", 128'(bus.MASTER_SEND_ADDR), 128'(slave_addr[0]));
    step();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b101;
    repeat (2) begin
      @(negedge clk);
      chk("lock_hold_addr", 128'(bus.MASTER_SEND_ADDR), 128'(slave_addr[0]));
      chk("lock_hold_ready", 128'(bus.SLAVE_RECEIVE_READY), 128'd0);
      step();
    end
    bus.MASTER_SEND_READY = 1'b1;
    exp_req(0);
    step();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b100;
    exp_req(2);
    step();

    // In-order response routing, with backpressure on slave 0.
    do_reset();
    bus.MASTER_SEND_READY = 1'b1;
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b100; exp_req(2); step();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b001; exp_req(0); step();
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b010; exp_req(1); step();
    bus.SLAVE_RECEIVE_ADDR_VALID = '0;
    bus.SLAVE_SEND_READY     = '1;
    bus.MASTER_RECEIVE_VALID = 1'b1;
    bus.MASTER_RECEIVE_DATA  = 32'h0000_000A;
    exp_rsp(2, 32'h0000_000A);
    step();
    bus.MASTER_RECEIVE_DATA = 32'h0000_000B;
    bus.SLAVE_SEND_READY    = 3'b110;
    repeat (2) begin
      @(negedge clk);
      chk("order_block_ready", 128'(bus.MASTER_RECEIVE_READY), 128'd0);
      chk("order_block_valid", 128'(bus.SLAVE_SEND_VALID), 128'b001);
      step();
    end
    bus.SLAVE_SEND_READY = '1;
    exp_rsp(0, 32'h0000_000B);
    step();
    // Slave 1 issues a new request while its own response is still pending.
    bus.MASTER_RECEIVE_DATA      = 32'h0000_000C;
    bus.SLAVE_RECEIVE_ADDR_VALID = 3'b010;
    exp_rsp(1, 32'h0000_000C);
    exp_req(1);
    step();
    idle();

    // A reset with three requests outstanding drops their tags.
    do_reset();
    for (int i = 0; i < 3; i++) exp_req(arb_exp[i]);
    bus.SLAVE_RECEIVE_ADDR_VALID = '1;
    bus.MASTER_SEND_READY        = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    bus.MASTER_RECEIVE_VALID = 1'b1;
    bus.SLAVE_SEND_READY     = '1;
    @(negedge clk);
    chk("midrst_addr_valid", 128'(bus.MASTER_SEND_ADDR_VALID), 128'd0);
    chk("midrst_recv_ready", 128'(bus.SLAVE_RECEIVE_READY), 128'd0);
    chk("midrst_mrecv_ready", 128'(bus.MASTER_RECEIVE_READY), 128'd0);
    step();
    rst = 1'b0;
    exp_req(arb_exp[0]);
    @(negedge clk);
    chk("post_rst_mrecv_ready", 128'(bus.MASTER_RECEIVE_READY), 128'd0);
    chk("post_rst_send_valid", 128'(bus.SLAVE_SEND_VALID), 128'd0);
    step();
    idle();
    step();

    chk("req_queue_drained", 128'(req_q.size()), 128'd0);
    chk("rsp_queue_drained", 128'(rsp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
